rom_stream_ctrl: RTL and testbench

ROM_STREAM_CTRL -- requirements
Module: rom_stream_ctrl

---
 rtl/rom_stream_pkg.sv | 13 +
 rtl/stream_fifo2.sv | 76 +++++++
 rtl/rom_stream_ctrl.sv | 112 +++++++++++
 tb/tb_rom_stream_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_stream_pkg.sv
// Shared constants and state encoding for the ROM streaming controller.
package rom_stream_pkg;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry sample buffer; head entry drives the registered outputs directly.
module stream_fifo2
    import rom_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    input  logic                  i_pop,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic [FIFO_CNT_W-1:0] o_count
);

    logic [DATA_WIDTH-1:0] r_data0;
    logic [DATA_WIDTH-1:0] r_data1;
    logic                  r_last0;
    logic                  r_last1;
    logic [FIFO_CNT_W-1:0] r_count;
    logic                  w_pop;
    logic                  w_push;

    assign w_pop  = i_pop & (r_count != '0);
    assign w_push = i_push & ((r_count != FIFO_CNT_W'(FIFO_DEPTH)) | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data0 <= '0;
            r_data1 <= '0;
            r_last0 <= 1'b0;
            r_last1 <= 1'b0;
            r_count <= '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == '0) begin
                        r_data0 <= i_data;
                        r_last0 <= i_last;
                    end else begin
                        r_data1 <= i_data;
                        r_last1 <= i_last;
                    end
                    r_count <= r_count + 1'b1;
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_last0 <= r_last1;
                    r_count <= r_count - 1'b1;
                end
                2'b11: begin
                    // Simultaneous push/pop keeps occupancy; new word lands behind any survivor.
                    if (r_count == FIFO_CNT_W'(1)) begin
                        r_data0 <= i_data;
                        r_last0 <= i_last;
                    end else begin
                        r_data0 <= r_data1;
                        r_last0 <= r_last1;
                        r_data1 <= i_data;
                        r_last1 <= i_last;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_valid = (r_count != '0);
    assign o_data  = r_data0;
    assign o_last  = r_last0;
    assign o_count = r_count;

endmodule

// File: rtl/rom_stream_ctrl.sv
// Streams an inclusive address range out of an external 1-cycle-latency ROM
// onto a valid/ready sample interface, optionally looping until stopped.
module rom_stream_ctrl
    import rom_stream_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [ADDRESS_WIDTH-1:0] end_addr,
    output logic [ADDRESS_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]    rom_dout,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic                     m_last,
    output logic                     busy,
    output logic                     done
);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [ADDRESS_WIDTH-1:0] r_base;
    logic [ADDRESS_WIDTH-1:0] r_end;
    logic                     r_loop;
    logic                     r_inflight;
    logic                     r_inflight_last;
    logic                     w_pop;
    logic                     w_issue;
    logic                     w_at_end;
    logic [FIFO_CNT_W-1:0]    w_count;
    logic [FIFO_CNT_W:0]      w_pending;

    assign w_pop    = m_valid & m_ready;
    assign w_at_end = (r_addr == r_end);

    // Reads outstanding after this cycle's pop must still fit in the buffer.
    assign w_pending = {1'b0, w_count} + {{FIFO_CNT_W{1'b0}}, r_inflight}
                     - {{FIFO_CNT_W{1'b0}}, w_pop};
    assign w_issue   = (r_state == ST_RUN) & ~stop
                     & (w_pending < (FIFO_CNT_W + 1)'(FIFO_DEPTH));

    always_comb begin
        w_state_nxt = r_state;
        done        = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (stop) w_state_nxt = ST_DRAIN;
                else if (w_issue && w_at_end && !r_loop) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!r_inflight && (w_count == '0)) begin
                    w_state_nxt = ST_IDLE;
                    done        = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_addr          <= '0;
            r_base          <= '0;
            r_end           <= '0;
            r_loop          <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue & w_at_end;
            if ((r_state == ST_IDLE) && start) begin
                r_addr <= base_addr;
                r_base <= base_addr;
                r_end  <= end_addr;
                r_loop <= loop_en;
            end else if (w_issue) begin
                r_addr <= (w_at_end && r_loop) ? r_base : r_addr + 1'b1;
            end
        end
    end

    assign rom_addr = r_addr;
    assign busy     = (r_state != ST_IDLE);

    stream_fifo2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_data  (rom_dout),
        .i_last  (r_inflight_last),
        .i_pop   (w_pop),
        .o_valid (m_valid),
        .o_data  (m_data),
        .o_last  (m_last),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_rom_stream_ctrl.sv
// Scoreboard bench for rom_stream_ctrl with a behavioural ROM and range model.
module tb_rom_stream_ctrl;

    localparam int AW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop_en = 1'b0;
    logic          m_ready = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] end_addr = '0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_dout;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_errors = 0;
    int n_pops = 0;
    bit rand_ready = 1'b0;
    bit mon_en = 1'b0;
    logic [DW:0] exp_q[$];

    rom_stream_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .loop_en   (loop_en),
        .base_addr (base_addr),
        .end_addr  (end_addr),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    // Synchronous ROM, one cycle of read latency.
    always @(posedge clk) rom_dout <= rom_word(rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    initial begin
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        logic [DW:0]   exp;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 32'(m_valid), 32'd1);
                    check("stall_data", 32'(m_data), 32'(prev_data));
                    check("stall_last", 32'(m_last), 32'(prev_last));
                end
                if (m_valid && m_ready) begin
                    n_pops++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_sample: got %0h expected none at %0t",
                                 {m_last, m_data}, $time);
                    end else begin
                        exp = exp_q.pop_front();
                        check("sample", 32'({m_last, m_data}), 32'(exp));
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) m_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic push_range(input logic [AW-1:0] b, input logic [AW-1:0] e);
        logic [AW-1:0] span;
        logic [AW-1:0] a;
        span = e - b;
        for (int i = 0; i <= int'(span); i++) begin
            a = b + AW'(i);
            exp_q.push_back({a == e, rom_word(a)});
        end
    endtask

    task automatic setup(input logic [AW-1:0] b, input logic [AW-1:0] e, input bit lp);
        base_addr = b;
        end_addr  = e;
        loop_en   = lp;
    endtask

    // Raises start after an edge; the following edge samples it.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
        check({name, "_done_pulse"}, 32'(done), 32'd0);
        check({name, "_idle"}, 32'(busy), 32'd0);
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic run_range(input string name, input logic [AW-1:0] b, input logic [AW-1:0] e,
                             input bit rnd);
        int cyc;
        setup(b, e, 1'b0);
        push_range(b, e);
        rand_ready = rnd;
        if (!rnd) m_ready = 1'b1;
        pulse_start();
        wait_done(name, cyc);
        rand_ready = 1'b0;
        m_ready    = 1'b1;
    endtask

    initial begin
        int cyc;
        int p0;
        bit hit;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_ready = 1'b1;
        mon_en  = 1'b1;
        @(posedge clk);
        #1;

        // Basic range with latency and done timing.
        setup(16'h0010, 16'h0013, 1'b0);
        push_range(16'h0010, 16'h0013);
        pulse_start();
        @(negedge clk);
        check("t1_valid_c0", 32'(m_valid), 32'd0);
        check("t1_busy_c0", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_valid_c1", 32'(m_valid), 32'd0);
        @(negedge clk);
        check("t1_valid_c2", 32'(m_valid), 32'd1);
        wait_done("t1", cyc);
        check("t1_done_cycle", 32'(cyc), 32'd4);

        run_range("t2_wrap", 16'hFFFE, 16'h0001, 1'b0);
        run_range("t3_stall", 16'h0020, 16'h002F, 1'b1);
        run_range("t_single", 16'h0077, 16'h0077, 1'b1);

        // Loop on a single address, stop after ten samples.
        setup(16'h0005, 16'h0005, 1'b1);
        for (int i = 0; i < 11; i++) exp_q.push_back({1'b1, rom_word(16'h0005)});
        m_ready = 1'b1;
        p0 = n_pops;
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (n_pops - p0 >= 10) hit = 1'b1;
        end
        check("t4_ten_samples", 32'(hit), 32'd1);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop    = 1'b0;
        loop_en = 1'b0;
        wait_done("t4", cyc);
        check("t4_total", 32'(n_pops - p0), 32'd11);

        // Reset one cycle after the first read was issued.
        setup(16'h0040, 16'h004F, 1'b0);
        pulse_start();
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_valid", 32'(m_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_rom_addr", 32'(rom_addr), 32'd0);
        @(negedge clk);
        check("t5_discard", 32'(m_valid), 32'd0);
        run_range("t5_restart", 16'h0030, 16'h0033, 1'b0);

        // Start while busy must not disturb the running stream.
        setup(16'h0050, 16'h0057, 1'b0);
        push_range(16'h0050, 16'h0057);
        pulse_start();
        repeat (2) @(posedge clk);
        #1;
        setup(16'h0099, 16'h009A, 1'b1);
        pulse_start();
        loop_en = 1'b0;
        wait_done("t6", cyc);

        // Start and stop together in IDLE starts the stream.
        setup(16'h0060, 16'h0062, 1'b0);
        push_range(16'h0060, 16'h0062);
        stop = 1'b1;
        pulse_start();
        stop = 1'b0;
        wait_done("t7", cyc);

        for (int k = 0; k < 6; k++) begin
            logic [AW-1:0] b;
            b = AW'($urandom);
            run_range("rnd", b, b + AW'($urandom_range(0, 11)), 1'b1);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
